// File: rtl/mc_control_fsm_if.sv
// Control-unit bundle between the multicycle controller and the datapath/memory.
// The master side is the controller; the slave side is the datapath/memory.
interface mc_control_fsm_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       opcode;
  logic             a_gtz;
  logic             mem_ready;
  logic [3:0]       state;
  logic             pc_en;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic             instr_done;
  logic             trap;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    input  opcode, a_gtz, mem_ready,
    output state, pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           instr_done, trap, retire_cnt
  );

  modport slave (
    output opcode, a_gtz, mem_ready,
    input  state, pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           instr_done, trap, retire_cnt
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/writeback,
// stalls on memory readiness, traps on unsupported opcodes and counts retirements.
module mc_control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  mc_control_fsm_if.master       bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_LW_WB     = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BGTZ      = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_JUMP      = 4'd11,
    S_TRAP      = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;

  state_e           state_q, state_d;
  logic             trap_q, trap_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  logic       pc_en_c, i_or_d_c, mem_read_c, mem_write_c, ir_write_c;
  logic       reg_dst_c, mem_to_reg_c, reg_write_c, alu_src_a_c;
  logic [1:0] alu_src_b_c, alu_op_c, pc_source_c;
  logic       instr_done_c;

  // Moore decode of the current state; the only input qualifiers are the
  // fetch handshake (commit IR/PC once), the branch flag and the store handshake.
  always_comb begin
    pc_en_c      = 1'b0;
    i_or_d_c     = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    alu_op_c     = 2'b00;
    pc_source_c  = 2'b00;
    instr_done_c = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        ir_write_c  = bus.mem_ready;
        pc_en_c     = bus.mem_ready;
      end
      S_DECODE: begin
        alu_src_b_c = 2'b11;
      end
      S_MEM_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
      end
      S_MEM_READ: begin
        mem_read_c = 1'b1;
        i_or_d_c   = 1'b1;
      end
      S_LW_WB: begin
        mem_to_reg_c = 1'b1;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write_c  = 1'b1;
        i_or_d_c     = 1'b1;
        instr_done_c = bus.mem_ready;
      end
      S_R_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b10;
      end
      S_R_WB: begin
        reg_dst_c    = 1'b1;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
      end
      S_BGTZ: begin
        alu_src_a_c  = 1'b1;
        alu_op_c     = 2'b01;
        pc_source_c  = 2'b01;
        pc_en_c      = bus.a_gtz;
        instr_done_c = 1'b1;
      end
      S_ADDI_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
      end
      S_ADDI_WB: begin
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
      end
      S_JUMP: begin
        pc_source_c  = 2'b10;
        pc_en_c      = 1'b1;
        instr_done_c = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Next-state, sticky trap and retirement counter; opcode is only looked at
  // in decode and mem-addr so IR changes elsewhere cannot disturb sequencing.
  always_comb begin
    state_d      = state_q;
    trap_d       = trap_q;
    retire_cnt_d = retire_cnt_q;
    if (instr_done_c) begin
      retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end
    unique case (state_q)
      S_FETCH:     if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (bus.opcode)
          OP_RTYPE:      state_d = S_R_EXEC;
          OP_ADDI:       state_d = S_ADDI_EXEC;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_J:          state_d = S_JUMP;
          OP_BGTZ:       state_d = S_BGTZ;
          default: begin
            state_d = S_TRAP;
            trap_d  = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:  state_d = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (bus.mem_ready) state_d = S_LW_WB;
      S_MEM_WRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_LW_WB, S_R_WB, S_BGTZ, S_ADDI_WB, S_JUMP: state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_FETCH;
    endcase
  end

  // State, trap and counter registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_FETCH;
      trap_q       <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      trap_q       <= trap_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Commit-type enables are suppressed for as long as reset is held so the
  // datapath never loads or writes memory while the core is being reset.
  assign bus.state      = state_q;
  assign bus.pc_en      = pc_en_c & ~reset;
  assign bus.ir_write   = ir_write_c & ~reset;
  assign bus.reg_write  = reg_write_c & ~reset;
  assign bus.mem_read   = mem_read_c & ~reset;
  assign bus.mem_write  = mem_write_c & ~reset;
  assign bus.i_or_d     = i_or_d_c;
  assign bus.reg_dst    = reg_dst_c;
  assign bus.mem_to_reg = mem_to_reg_c;
  assign bus.alu_src_a  = alu_src_a_c;
  assign bus.alu_src_b  = alu_src_b_c;
  assign bus.alu_op     = alu_op_c;
  assign bus.pc_source  = pc_source_c;
  assign bus.instr_done = instr_done_c;
  assign bus.trap       = trap_q;
  assign bus.retire_cnt = retire_cnt_q;

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multicycle control unit for the MIPS core: holds the 4-bit state register, sequences fetch/decode/execute/memory/writeback, and drives every datapath enable and mux select. It sits between the instruction register (opcode source) and the datapath/memory. It adds memory-ready stalls, a sticky trap for unsupported opcodes, and a retired-instruction counter.

## Interface
Parameters:
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  asynchronous, active-high
- opcode  input  6  IR[31:26], stable from the cycle after S0 completes
- a_gtz  input  1  datapath flag: register A signed > 0
- mem_ready  input  1  memory completes the current access this cycle
- state  output  4  current state encoding (debug)
- pc_en  output  1  PC load enable
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  IR load enable
- reg_dst  output  1  0 = rt, 1 = rd
- mem_to_reg  output  1  0 = ALUOut, 1 = MDR
- reg_write  output  1  register file write enable
- alu_src_a  output  1  0 = PC, 1 = A
- alu_src_b  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- alu_op  output  2  00 = add, 01 = sub, 10 = funct decode
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  output  1  one-cycle pulse when an instruction retires
- trap  output  1  sticky: unsupported opcode decoded
- retire_cnt  output  CNT_W  retired-instruction count

## Operation
- States: S0 fetch, S1 decode, S2 mem-addr, S3 mem-read, S4 lw-writeback, S5 mem-write, S6 R-exec, S7 R-writeback, S8 bgtz, S9 addi-exec, S10 addi-writeback, S11 jump, S12 trap.
- Transitions:
  - S0→S1 only when mem_ready; otherwise hold in S0.
  - S1 by opcode: 000000→S6, 001000→S9, 100011/101011→S2, 000010→S11, 000111→S8; any other→S12.
  - S2→S3 (lw) or S5 (sw).
  - S3→S4 only when mem_ready; otherwise hold.
  - S5→S0 only when mem_ready; otherwise hold.
  - S6→S7, S9→S10; S4, S7, S8, S10, S11→S0.
  - S12 holds until reset.
- Moore outputs per state. Every signal not listed is 0.
  - S0: mem_read=1, alu_src_b=01, ir_write=mem_ready, pc_en=mem_ready.
  - S1: alu_src_b=11.
  - S2: alu_src_a=1, alu_src_b=10.
  - S3: mem_read=1, i_or_d=1.
  - S4: mem_to_reg=1, reg_write=1.
  - S5: mem_write=1, i_or_d=1.
  - S6: alu_src_a=1, alu_op=10.
  - S7: reg_dst=1, reg_write=1.
  - S8: alu_src_a=1, alu_op=01, pc_source=01, pc_en=a_gtz.
  - S9: alu_src_a=1, alu_src_b=10.
  - S10: reg_write=1.
  - S11: pc_source=10, pc_en=1.
  - S12: all 0.
- instr_done=1 in the final cycle of each instruction:
  - S4, S7, S8, S10, S11 unconditionally;
  - S5 only when mem_ready.
- retire_cnt increments by 1 on each instr_done and wraps modulo 2^CNT_W.
- trap sets on the S1→S12 transition and stays set until reset.

## Timing
- Asynchronous reset: state=S0, trap=0, retire_cnt=0 immediately.
- While reset is high, pc_en, ir_write, reg_write, mem_read and mem_write are forced to 0.
- First fetch request: the first rising edge after reset deasserts.
- Latencies with zero wait states:
  - R-type, addi: 4 cycles;
  - lw: 5 cycles;
  - sw: 4 cycles;
  - bgtz, jump: 3 cycles.
- Each mem_ready-low cycle in S0, S3 or S5 adds one cycle.
- In a stalled state, outputs are held and nothing is double-committed:
  - ir_write and pc_en are only high on the completing cycle of S0;
  - mem_write stays high until mem_ready.
- mem_ready is ignored in all states other than S0, S3, S5.
- opcode is sampled only in S1 and S2. A change in any other state has no effect.
- Reset mid-instruction aborts the instruction: no retire, counter cleared.

## Test plan
- Reset, mem_ready=1, opcode=000000 → states 0,1,6,7,0. reg_write=1 and reg_dst=1 only in S7. instr_done pulses once; retire_cnt=1.
- lw (100011) with mem_ready low for 2 cycles in S3 → S3 held 3 cycles. No reg_write until S4. Total 7 cycles; mem_to_reg=1 in S4.
- sw (101011) with mem_ready low 1 cycle in S5 → mem_write high 2 cycles; instr_done only on the mem_ready cycle.
- bgtz (000111) with a_gtz=1, then a_gtz=0 → pc_en=1 with pc_source=01 in S8, then pc_en=0. Both retire; retire_cnt=2.
- opcode=111111 in S1 → S12, trap=1, all enables 0 for 10+ cycles. Asserting reset clears state=0 and trap=0.
- CNT_W=4, run 17 addi (001000) instructions → retire_cnt wraps to 1. Each instruction takes the state sequence 0,1,9,10.
